// File: rtl/data_path_param_pkg.sv
// Shared encodings for the parametrised datapath: ALU ops, bus selects and condition codes.
// The condition evaluator lives here so any control-side model can reuse the same decode.
package data_path_param_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_INC  = 3'b100;
    localparam logic [2:0] ALU_DEC  = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] B2_ALU  = 2'b00;
    localparam logic [1:0] B2_BUS1 = 2'b01;
    localparam logic [1:0] B2_MEM  = 2'b10;
    localparam logic [1:0] B2_REL  = 2'b11;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_N      = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_NN     = 3'b101;
    localparam logic [2:0] COND_NZ     = 3'b110;
    localparam logic [2:0] COND_NC     = 3'b111;

    localparam int B1_PC   = 0;
    localparam int B1_SP   = 1;
    localparam int B1_REG0 = 2;

    // nzvc is packed {N,Z,V,C}
    function automatic logic cond_eval(input logic [2:0] sel, input logic [3:0] nzvc);
        logic r;
        r = 1'b1;
        case (sel)
            COND_ALWAYS: r = 1'b1;
            COND_N:      r = nzvc[3];
            COND_Z:      r = nzvc[2];
            COND_V:      r = nzvc[1];
            COND_C:      r = nzvc[0];
            COND_NN:     r = ~nzvc[3];
            COND_NZ:     r = ~nzvc[2];
            COND_NC:     r = ~nzvc[0];
            default:     r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_path_param_alu.sv
// Combinational DW-bit ALU producing a result and {N,Z,V,C} flags.
// Carry is a true carry-out for add/inc and a borrow for sub/dec.
module alu_param
    import data_path_param_pkg::*;
#(
    parameter int DW = 8
) (
    output logic [DW-1:0] Result,
    output logic [3:0]    NZVC,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [2:0]    ALU_Sel
);

    localparam int M = DW - 1;
    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW:0]   ext;
    logic [DW-1:0] res;
    logic          v;
    logic          c;

    always_comb begin
        ext = '0;
        res = '0;
        v   = 1'b0;
        c   = 1'b0;
        case (ALU_Sel)
            ALU_ADD: begin
                ext = {1'b0, A} + {1'b0, B};
                res = ext[DW-1:0];
                c   = ext[DW];
                v   = (A[M] == B[M]) && (res[M] != A[M]);
            end
            ALU_SUB: begin
                res = A - B;
                c   = (A < B);
                v   = (A[M] != B[M]) && (res[M] != A[M]);
            end
            ALU_AND: res = A & B;
            ALU_OR:  res = A | B;
            ALU_INC: begin
                ext = {1'b0, A} + {1'b0, ONE};
                res = ext[DW-1:0];
                c   = ext[DW];
                v   = ~A[M] & res[M];
            end
            ALU_DEC: begin
                res = A - ONE;
                c   = (A == '0);
                v   = A[M] & ~res[M];
            end
            ALU_XOR:  res = A ^ B;
            ALU_PASS: res = A;
            default:  res = A;
        endcase
    end

    assign Result = res;
    assign NZVC   = {res[M], (res == '0), v, c};

endmodule

// File: rtl/data_path_param.sv
// Parametrised computer datapath: register file, PC, SP with guarded push/pop, IR, MAR, CCR.
// Bus1/Bus2 are combinational, so a register read in the same cycle as its write sees the old value.
module data_path_param
    import data_path_param_pkg::*;
#(
    parameter int            DW       = 8,
    parameter int            NREG     = 4,
    parameter logic [DW-1:0] SP_RESET = '1,
    localparam int           B1W      = $clog2(NREG + 2),
    localparam int           RW       = $clog2(NREG)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [DW-1:0]   from_memory,
    input  logic [B1W-1:0]  Bus1_Sel,
    input  logic [1:0]      Bus2_Sel,
    input  logic [RW-1:0]   ALU_A_Sel,
    input  logic [RW-1:0]   ALU_B_Sel,
    input  logic [2:0]      ALU_Sel,
    input  logic [NREG-1:0] Reg_Load,
    input  logic            IR_Load,
    input  logic            MAR_Load,
    input  logic            PC_Load,
    input  logic            PC_Inc,
    input  logic            CCR_Load,
    input  logic            SP_Load,
    input  logic            SP_Inc,
    input  logic            SP_Dec,
    input  logic [2:0]      Cond_Sel,
    output logic [DW-1:0]   address,
    output logic [DW-1:0]   to_memory,
    output logic [DW-1:0]   IR_out,
    output logic [3:0]      CCR_Result,
    output logic            cond_true,
    output logic            stack_err
);

    localparam logic [DW-1:0] ONE    = DW'(1);
    localparam logic [DW-1:0] SP_TOP = SP_RESET;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] pc, sp, ir, mar;
    logic [3:0]    ccr;
    logic [DW-1:0] bus1, bus2;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [3:0]    alu_nzvc;

    // Unused Bus1 codes fall back to the PC source
    always_comb begin
        bus1 = pc;
        if (Bus1_Sel == B1W'(B1_SP)) bus1 = sp;
        for (int k = 0; k < NREG; k++) begin
            if (Bus1_Sel == B1W'(B1_REG0 + k)) bus1 = regs[k];
        end
    end

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        for (int k = 0; k < NREG; k++) begin
            if (ALU_A_Sel == RW'(k)) alu_a = regs[k];
            if (ALU_B_Sel == RW'(k)) alu_b = regs[k];
        end
    end

    alu_param #(.DW(DW)) u_alu (
        .Result  (alu_result),
        .NZVC    (alu_nzvc),
        .A       (alu_a),
        .B       (alu_b),
        .ALU_Sel (ALU_Sel)
    );

    // from_memory is already DW wide, so its sign extension is the identity modulo 2^DW
    always_comb begin
        bus2 = alu_result;
        case (Bus2_Sel)
            B2_ALU:  bus2 = alu_result;
            B2_BUS1: bus2 = bus1;
            B2_MEM:  bus2 = from_memory;
            B2_REL:  bus2 = pc + from_memory;
            default: bus2 = alu_result;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (Reg_Load[k]) regs[k] <= bus2;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ir  <= '0;
            mar <= '0;
            pc  <= '0;
            ccr <= '0;
        end else begin
            if (IR_Load)  ir  <= bus2;
            if (MAR_Load) mar <= bus2;
            if (CCR_Load) ccr <= alu_nzvc;
            if (PC_Load)       pc <= bus2;
            else if (PC_Inc)   pc <= pc + ONE;
        end
    end

    // Simultaneous inc and dec cancel out and never flag an error
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sp        <= SP_RESET;
            stack_err <= 1'b0;
        end else if (SP_Load) begin
            sp        <= bus2;
            stack_err <= 1'b0;
        end else if (SP_Dec && !SP_Inc) begin
            if (sp == '0) stack_err <= 1'b1;
            else          sp        <= sp - ONE;
        end else if (SP_Inc && !SP_Dec) begin
            if (sp == SP_TOP) stack_err <= 1'b1;
            else              sp        <= sp + ONE;
        end
    end

    assign address    = mar;
    assign to_memory  = bus1;
    assign IR_out     = ir;
    assign CCR_Result = ccr;
    assign cond_true  = cond_eval(Cond_Sel, ccr);

endmodule

// File: tb/tb_data_path_param.sv
// Directed bench for data_path_param (DW=8, NREG=4) with hand-computed expectations.
module tb_data_path_param;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] from_memory;
    logic [2:0] Bus1_Sel;
    logic [1:0] Bus2_Sel;
    logic [1:0] ALU_A_Sel, ALU_B_Sel;
    logic [2:0] ALU_Sel;
    logic [3:0] Reg_Load;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load;
    logic       SP_Load, SP_Inc, SP_Dec;
    logic [2:0] Cond_Sel;
    logic [7:0] address, to_memory, IR_out;
    logic [3:0] CCR_Result;
    logic       cond_true, stack_err;

    int n_checks = 0;
    int n_fail   = 0;

    data_path_param dut (
        .Clk(Clk), .Reset(Reset), .from_memory(from_memory),
        .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
        .ALU_A_Sel(ALU_A_Sel), .ALU_B_Sel(ALU_B_Sel), .ALU_Sel(ALU_Sel),
        .Reg_Load(Reg_Load), .IR_Load(IR_Load), .MAR_Load(MAR_Load),
        .PC_Load(PC_Load), .PC_Inc(PC_Inc), .CCR_Load(CCR_Load),
        .SP_Load(SP_Load), .SP_Inc(SP_Inc), .SP_Dec(SP_Dec),
        .Cond_Sel(Cond_Sel), .address(address), .to_memory(to_memory),
        .IR_out(IR_out), .CCR_Result(CCR_Result), .cond_true(cond_true),
        .stack_err(stack_err)
    );

    always #5 Clk = ~Clk;

    task automatic idle();
        from_memory = 8'h00; Bus1_Sel = 3'd0; Bus2_Sel = 2'b10;
        ALU_A_Sel = 2'd0; ALU_B_Sel = 2'd0; ALU_Sel = 3'b111; Reg_Load = 4'b0000;
        IR_Load = 1'b0; MAR_Load = 1'b0; PC_Load = 1'b0; PC_Inc = 1'b0; CCR_Load = 1'b0;
        SP_Load = 1'b0; SP_Inc = 1'b0; SP_Dec = 1'b0; Cond_Sel = 3'b000;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_reg(input int k, input logic [7:0] v);
        idle(); from_memory = v; Reg_Load = 4'(1 << k); tick(); idle();
    endtask

    task automatic load_pc(input logic [7:0] v);
        idle(); from_memory = v; PC_Load = 1'b1; tick(); idle();
    endtask

    task automatic load_sp(input logic [7:0] v);
        idle(); from_memory = v; SP_Load = 1'b1; tick(); idle();
    endtask

    task automatic peek(input logic [2:0] sel, output logic [7:0] v);
        Bus1_Sel = sel; #1; v = to_memory;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        Reset = 1'b1; idle();
        repeat (2) @(posedge Clk);
        #1;
        n_checks++; if (address !== 8'h00) begin n_fail++; $display("FAIL reset_mar: got %h expected 00", address); end
        n_checks++; if (IR_out !== 8'h00) begin n_fail++; $display("FAIL reset_ir: got %h expected 00", IR_out); end
        n_checks++; if (CCR_Result !== 4'h0) begin n_fail++; $display("FAIL reset_ccr: got %b expected 0000", CCR_Result); end
        n_checks++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", stack_err); end
        peek(3'd0, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", v); end
        peek(3'd1, v);
        n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL reset_sp: got %h expected ff", v); end
        for (int k = 0; k < 4; k++) begin
            peek(3'(k + 2), v);
            n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_r%0d: got %h expected 00", k, v); end
        end
        Reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        load_pc(8'h37);
        load_sp(8'hFF);
        SP_Inc = 1'b1; tick(); idle();
        SP_Dec = 1'b1; repeat (15) tick(); idle();
        load_reg(2, 8'h99);
        from_memory = 8'hA5; IR_Load = 1'b1; tick(); idle();
        from_memory = 8'h5A; MAR_Load = 1'b1; tick(); idle();
        ALU_Sel = 3'b111; ALU_A_Sel = 2'd0; CCR_Load = 1'b1; tick(); idle();
        peek(3'd0, v);
        n_checks++; if (v !== 8'h37) begin n_fail++; $display("FAIL pre_pc: got %h expected 37", v); end
        peek(3'd1, v);
        n_checks++; if (v !== 8'hF0) begin n_fail++; $display("FAIL pre_sp: got %h expected f0", v); end
        n_checks++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL pre_err: got %b expected 1", stack_err); end
        n_checks++; if (CCR_Result !== 4'b0100) begin n_fail++; $display("FAIL pre_ccr: got %b expected 0100", CCR_Result); end
        n_checks++; if (IR_out !== 8'hA5) begin n_fail++; $display("FAIL pre_ir: got %h expected a5", IR_out); end
        n_checks++; if (address !== 8'h5A) begin n_fail++; $display("FAIL pre_mar: got %h expected 5a", address); end
        // keep some loads active so a late reset would expose partial updates
        @(posedge Clk); #3;
        from_memory = 8'h77; PC_Load = 1'b1; SP_Inc = 1'b1; Reg_Load = 4'b1111;
        Reset = 1'b1; #1;
        n_checks++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b expected 0", stack_err); end
        n_checks++; if (IR_out !== 8'h00) begin n_fail++; $display("FAIL mid_ir: got %h expected 00", IR_out); end
        n_checks++; if (address !== 8'h00) begin n_fail++; $display("FAIL mid_mar: got %h expected 00", address); end
        n_checks++; if (CCR_Result !== 4'h0) begin n_fail++; $display("FAIL mid_ccr: got %b expected 0000", CCR_Result); end
        peek(3'd0, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_pc: got %h expected 00", v); end
        peek(3'd1, v);
        n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL mid_sp: got %h expected ff", v); end
        peek(3'd4, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_r2: got %h expected 00", v); end
        @(posedge Clk); #1;
        peek(3'd0, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_pc_held: got %h expected 00", v); end
        idle();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_add();
        logic [7:0] v;
        logic [7:0] exp_cond;
        load_reg(0, 8'h7F);
        load_reg(1, 8'h01);
        Bus2_Sel = 2'b00; ALU_A_Sel = 2'd0; ALU_B_Sel = 2'd1; ALU_Sel = 3'b000;
        Reg_Load = 4'b0100; CCR_Load = 1'b1;
        peek(3'd4, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL add_old_r2: got %h expected 00", v); end
        tick(); idle();
        peek(3'd4, v);
        n_checks++; if (v !== 8'h80) begin n_fail++; $display("FAIL add_r2: got %h expected 80", v); end
        n_checks++; if (CCR_Result !== 4'b1010) begin n_fail++; $display("FAIL add_ccr: got %b expected 1010", CCR_Result); end
        exp_cond = 8'b1100_1011;
        for (int c = 0; c < 8; c++) begin
            Cond_Sel = 3'(c); #1;
            n_checks++; if (cond_true !== exp_cond[c]) begin n_fail++; $display("FAIL cond_%0d: got %b expected %b", c, cond_true, exp_cond[c]); end
        end
        idle();
    endtask

    task automatic test_alu_sub_dec();
        logic [7:0] v;
        load_reg(0, 8'h00);
        load_reg(1, 8'h01);
        Bus2_Sel = 2'b00; ALU_A_Sel = 2'd0; ALU_B_Sel = 2'd1; ALU_Sel = 3'b001;
        Reg_Load = 4'b1000; CCR_Load = 1'b1; tick(); idle();
        peek(3'd5, v);
        n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL sub_r3: got %h expected ff", v); end
        n_checks++; if (CCR_Result !== 4'b1001) begin n_fail++; $display("FAIL sub_ccr: got %b expected 1001", CCR_Result); end
        ALU_A_Sel = 2'd1; ALU_Sel = 3'b111; CCR_Load = 1'b1; tick(); idle();
        n_checks++; if (CCR_Result !== 4'b0000) begin n_fail++; $display("FAIL pass_ccr: got %b expected 0000", CCR_Result); end
        Bus2_Sel = 2'b00; ALU_A_Sel = 2'd0; ALU_Sel = 3'b101;
        Reg_Load = 4'b0100; CCR_Load = 1'b1; tick(); idle();
        peek(3'd4, v);
        n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL dec_r2: got %h expected ff", v); end
        n_checks++; if (CCR_Result !== 4'b1001) begin n_fail++; $display("FAIL dec_ccr: got %b expected 1001", CCR_Result); end
    endtask

    task automatic test_alu_logic();
        logic [7:0] v;
        logic [2:0] ops [4];
        logic [7:0] exp_r [4];
        logic [3:0] exp_f [4];
        ops[0] = 3'b010; exp_r[0] = 8'h88; exp_f[0] = 4'b1000;
        ops[1] = 3'b011; exp_r[1] = 8'hEE; exp_f[1] = 4'b1000;
        ops[2] = 3'b110; exp_r[2] = 8'h66; exp_f[2] = 4'b0000;
        ops[3] = 3'b000; exp_r[3] = 8'h76; exp_f[3] = 4'b0011;
        load_reg(0, 8'hCC);
        load_reg(1, 8'hAA);
        for (int i = 0; i < 4; i++) begin
            Bus2_Sel = 2'b00; ALU_A_Sel = 2'd0; ALU_B_Sel = 2'd1; ALU_Sel = ops[i];
            Reg_Load = 4'b1000; CCR_Load = 1'b1; tick(); idle();
            peek(3'd5, v);
            n_checks++; if (v !== exp_r[i]) begin n_fail++; $display("FAIL logic_res_%0d: got %h expected %h", i, v, exp_r[i]); end
            n_checks++; if (CCR_Result !== exp_f[i]) begin n_fail++; $display("FAIL logic_ccr_%0d: got %b expected %b", i, CCR_Result, exp_f[i]); end
        end
        load_reg(1, 8'hFF);
        Bus2_Sel = 2'b00; ALU_A_Sel = 2'd1; ALU_Sel = 3'b100; Reg_Load = 4'b1000; CCR_Load = 1'b1; tick(); idle();
        peek(3'd5, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL inc_wrap: got %h expected 00", v); end
        n_checks++; if (CCR_Result !== 4'b0101) begin n_fail++; $display("FAIL inc_ccr: got %b expected 0101", CCR_Result); end
    endtask

    task automatic test_stack();
        logic [7:0] v;
        load_sp(8'h01);
        SP_Dec = 1'b1; tick(); idle();
        peek(3'd1, v);
        n_checks++; if (v !== 8'h00 || stack_err !== 1'b0) begin n_fail++; $display("FAIL sp_dec1: got sp %h err %b expected sp 00 err 0", v, stack_err); end
        SP_Dec = 1'b1; tick(); idle();
        peek(3'd1, v);
        n_checks++; if (v !== 8'h00 || stack_err !== 1'b1) begin n_fail++; $display("FAIL sp_under: got sp %h err %b expected sp 00 err 1", v, stack_err); end
        SP_Inc = 1'b1; SP_Dec = 1'b1; tick(); idle();
        peek(3'd1, v);
        n_checks++; if (v !== 8'h00 || stack_err !== 1'b1) begin n_fail++; $display("FAIL sp_both: got sp %h err %b expected sp 00 err 1", v, stack_err); end
        load_sp(8'h10);
        peek(3'd1, v);
        n_checks++; if (v !== 8'h10 || stack_err !== 1'b0) begin n_fail++; $display("FAIL sp_load: got sp %h err %b expected sp 10 err 0", v, stack_err); end
        SP_Inc = 1'b1; tick(); idle();
        peek(3'd1, v);
        n_checks++; if (v !== 8'h11) begin n_fail++; $display("FAIL sp_inc: got %h expected 11", v); end
        load_sp(8'hFF);
        SP_Inc = 1'b1; tick(); idle();
        peek(3'd1, v);
        n_checks++; if (v !== 8'hFF || stack_err !== 1'b1) begin n_fail++; $display("FAIL sp_over: got sp %h err %b expected sp ff err 1", v, stack_err); end
        SP_Load = 1'b1; SP_Dec = 1'b1; from_memory = 8'h20; tick(); idle();
        peek(3'd1, v);
        n_checks++; if (v !== 8'h20 || stack_err !== 1'b0) begin n_fail++; $display("FAIL sp_load_prio: got sp %h err %b expected sp 20 err 0", v, stack_err); end
    endtask

    task automatic test_pc();
        logic [7:0] v;
        load_pc(8'hFF);
        PC_Inc = 1'b1; tick(); idle();
        peek(3'd0, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL pc_wrap: got %h expected 00", v); end
        from_memory = 8'h42; PC_Load = 1'b1; PC_Inc = 1'b1; tick(); idle();
        peek(3'd0, v);
        n_checks++; if (v !== 8'h42) begin n_fail++; $display("FAIL pc_prio: got %h expected 42", v); end
    endtask

    task automatic test_relative();
        logic [7:0] v;
        load_pc(8'h10);
        from_memory = 8'hFC; Bus2_Sel = 2'b11; PC_Load = 1'b1; tick(); idle();
        peek(3'd0, v);
        n_checks++; if (v !== 8'h0C) begin n_fail++; $display("FAIL rel_back: got %h expected 0c", v); end
        peek(3'd7, v);
        n_checks++; if (v !== 8'h0C) begin n_fail++; $display("FAIL bus1_sel7: got %h expected 0c", v); end
        peek(3'd6, v);
        n_checks++; if (v !== 8'h0C) begin n_fail++; $display("FAIL bus1_sel6: got %h expected 0c", v); end
        load_pc(8'hF0);
        from_memory = 8'h20; Bus2_Sel = 2'b11; PC_Load = 1'b1; tick(); idle();
        peek(3'd0, v);
        n_checks++; if (v !== 8'h10) begin n_fail++; $display("FAIL rel_fwd_wrap: got %h expected 10", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        from_memory = 8'h3C; Reg_Load = 4'b1111; tick();
        from_memory = 8'h00; Reg_Load = 4'b0010; Bus2_Sel = 2'b10; tick(); idle();
        for (int k = 0; k < 4; k++) begin
            peek(3'(k + 2), v);
            n_checks++; if (v !== ((k == 1) ? 8'h00 : 8'h3C)) begin n_fail++; $display("FAIL multi_r%0d: got %h", k, v); end
        end
        load_sp(8'h81);
        Bus1_Sel = 3'd1; Bus2_Sel = 2'b01; MAR_Load = 1'b1; IR_Load = 1'b1; tick(); idle();
        n_checks++; if (address !== 8'h81) begin n_fail++; $display("FAIL mar_bus1: got %h expected 81", address); end
        n_checks++; if (IR_out !== 8'h81) begin n_fail++; $display("FAIL ir_bus1: got %h expected 81", IR_out); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_alu_add();
        test_alu_sub_dec();
        test_alu_logic();
        test_stack();
        test_pc();
        test_relative();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
